// File: rtl/serial_to_parallel_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_to_parallel_deserializer_if
// Brief   : Serial-in / parallel-out bundle with valid/ready output handshake.
// Revision: 1.0
// ============================================================================
interface serial_to_parallel_deserializer_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH);

    logic             flush;
    logic             ser_in;
    logic             ser_valid;
    logic             par_ready;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             overrun;
    logic [CW-1:0]    bit_count;

    // master: the environment feeding bits and consuming words
    modport master (
        output flush, ser_in, ser_valid, par_ready,
        input  par_out, par_valid, overrun, bit_count
    );

    modport slave (
        input  flush, ser_in, ser_valid, par_ready,
        output par_out, par_valid, overrun, bit_count
    );
endinterface
`default_nettype wire

// File: rtl/serial_to_parallel_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : serial_to_parallel_deserializer
// Brief   : Double-buffered serial-to-parallel converter, WIDTH-bit words.
// Revision: 1.0
// ============================================================================
module serial_to_parallel_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    serial_to_parallel_deserializer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] par_out_q;
    logic [CW-1:0]    bit_count_q;
    logic [CW-1:0]    bit_count_d;
    logic             overrun_q;
    logic             word_done;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_d = {shift_q[WIDTH-2:0], bus.ser_in};
        end else begin : g_lsb_first
            assign shift_d = {bus.ser_in, shift_q[WIDTH-1:1]};
        end
    endgenerate

    // shift_d already holds the completing bit, so it is the finished word
    assign word_done   = bus.ser_valid && (bit_count_q == CW'(WIDTH - 1));
    assign bit_count_d = word_done ? '0 : bit_count_q + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            shift_q     <= '0;
            par_out_q   <= '0;
            bit_count_q <= '0;
            overrun_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= EMPTY;
            shift_q     <= '0;
            bit_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (bus.ser_valid) begin
                shift_q     <= shift_d;
                bit_count_q <= bit_count_d;
            end
            case (state_q)
                EMPTY: begin
                    if (word_done) begin
                        par_out_q <= shift_d;
                        state_q   <= FULL;
                    end
                end
                FULL: begin
                    if (bus.par_ready) begin
                        if (word_done) par_out_q <= shift_d;
                        else           state_q   <= EMPTY;
                    end else if (word_done) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.par_out   = par_out_q;
    assign bus.par_valid = (state_q == FULL);
    assign bus.overrun   = overrun_q;
    assign bus.bit_count = bit_count_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel_deserializer.sv
`default_nettype none
// Bench: MSB-first and LSB-first instances share stimulus; an arithmetic
// word/buffer model predicts every output after each edge.
module tb_serial_to_parallel_deserializer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0, ser_in = 1'b0, ser_valid = 1'b0, par_ready = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    // model state, index 0 = MSB-first, 1 = LSB-first
    int m_cnt[2], m_acc[2], m_out[2], m_valid[2], m_ovr[2];

    serial_to_parallel_deserializer_if #(.WIDTH(W)) ifa ();
    serial_to_parallel_deserializer_if #(.WIDTH(W)) ifb ();

    assign ifa.flush = flush;     assign ifb.flush = flush;
    assign ifa.ser_in = ser_in;   assign ifb.ser_in = ser_in;
    assign ifa.ser_valid = ser_valid; assign ifb.ser_valid = ser_valid;
    assign ifa.par_ready = par_ready; assign ifb.par_ready = par_ready;

    serial_to_parallel_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    serial_to_parallel_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_acc[k] = 0; m_out[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
        end
    endtask

    task automatic model_edge(input int fl, input int sv, input int sin, input int rdy);
        for (int k = 0; k < 2; k++) begin
            int done;
            int word;
            done = 0;
            word = 0;
            if (fl != 0) begin
                m_cnt[k] = 0; m_acc[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
            end else begin
                m_ovr[k] = 0;
                if (sv != 0) begin
                    if (k == 0) m_acc[k] = m_acc[k] * 2 + sin;
                    else        m_acc[k] = m_acc[k] + sin * (1 << m_cnt[k]);
                    m_cnt[k]++;
                    if (m_cnt[k] == W) begin
                        done = 1; word = m_acc[k]; m_cnt[k] = 0; m_acc[k] = 0;
                    end
                end
                if (done != 0) begin
                    if (m_valid[k] == 0 || rdy != 0) begin
                        m_out[k] = word; m_valid[k] = 1;
                    end else begin
                        m_ovr[k] = 1;
                    end
                end else if (rdy != 0) begin
                    m_valid[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("msb.par_valid", 32'(ifa.par_valid), 32'(m_valid[0]));
        chk("msb.par_out",   32'(ifa.par_out),   32'(m_out[0]));
        chk("msb.overrun",   32'(ifa.overrun),   32'(m_ovr[0]));
        chk("msb.bit_count", 32'(ifa.bit_count), 32'(m_cnt[0]));
        chk("lsb.par_valid", 32'(ifb.par_valid), 32'(m_valid[1]));
        chk("lsb.par_out",   32'(ifb.par_out),   32'(m_out[1]));
        chk("lsb.overrun",   32'(ifb.overrun),   32'(m_ovr[1]));
        chk("lsb.bit_count", 32'(ifb.bit_count), 32'(m_cnt[1]));
    endtask

    // inputs are applied, one edge is taken, then outputs are sampled 1 ns later
    task automatic cyc(input int fl, input int sv, input int sin, input int rdy);
        flush = fl[0]; ser_valid = sv[0]; ser_in = sin[0]; par_ready = rdy[0];
        @(posedge clk);
        model_edge(fl, sv, sin, rdy);
        #1;
        compare_all();
    endtask

    task automatic feed(input logic [7:0] bits, input int n, input int rdy);
        for (int i = n - 1; i >= 0; i--) cyc(0, 1, int'(bits[i]), rdy);
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset.par_valid", 32'(ifa.par_valid), 32'd0);
        chk("reset.par_out",   32'(ifa.par_out),   32'd0);
        chk("reset.overrun",   32'(ifa.overrun),   32'd0);
        chk("reset.bit_count", 32'(ifa.bit_count), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // word with no consumer
        feed(8'b1011, 4, 0);
        chk("t1.par_out", 32'(ifa.par_out), 32'hB);
        chk("t1.par_valid", 32'(ifa.par_valid), 32'd1);
        chk("t1.bit_count", 32'(ifa.bit_count), 32'd0);

        // second word dropped while buffer full
        feed(8'b0110, 4, 0);
        chk("t2.overrun", 32'(ifa.overrun), 32'd1);
        chk("t2.par_out", 32'(ifa.par_out), 32'hB);
        cyc(0, 0, 0, 0);
        chk("t2.overrun_clear", 32'(ifa.overrun), 32'd0);

        // back-to-back words with consumer always ready
        cyc(0, 0, 0, 1);
        feed(8'b1011, 4, 1);
        chk("t3.word1", 32'(ifa.par_out), 32'hB);
        feed(8'b0110, 4, 1);
        chk("t3.word2", 32'(ifa.par_out), 32'h6);
        chk("t3.no_bubble", 32'(ifa.par_valid), 32'd1);
        cyc(0, 0, 0, 1);

        // gaps between bits
        feed(8'b11, 2, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1);
            chk("t4.gap_count", 32'(ifa.bit_count), 32'd2);
        end
        feed(8'b01, 2, 1);
        chk("t4.par_out", 32'(ifa.par_out), 32'hD);

        // LSB-first instance, first bit lands in bit 0
        feed(8'b1000, 4, 1);
        chk("t5.lsb_out", 32'(ifb.par_out), 32'h1);
        chk("t5.msb_out", 32'(ifa.par_out), 32'h8);

        // flush mid-word
        feed(8'b11, 2, 1);
        cyc(1, 1, 1, 1);
        chk("t6.flush_count", 32'(ifa.bit_count), 32'd0);
        feed(8'b0101, 4, 1);
        chk("t6.flush_word", 32'(ifa.par_out), 32'h5);

        // asynchronous reset mid-word with buffer full
        feed(8'b11, 2, 0);
        #2 reset = 1'b0;
        #1;
        chk("t6.rst_out",   32'(ifa.par_out),   32'd0);
        chk("t6.rst_valid", 32'(ifa.par_valid), 32'd0);
        chk("t6.rst_count", 32'(ifb.bit_count), 32'd0);
        model_reset();
        #1 reset = 1'b1;
        feed(8'b0101, 4, 0);
        chk("t6.rst_word", 32'(ifa.par_out), 32'h5);
        chk("t6.rst_word_lsb", 32'(ifb.par_out), 32'hA);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 19) == 0) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
